mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning line address width (tag + set index).
REQ-002 SHALL have parameter LINE_W, default 128, meaning cache line width in bits.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have ports ic_read input 1 (I-cache line read request); ic_write input 1 (I-cache line write request); ic_addr input ADDR_W; ic_wdata input LINE_W.
REQ-005 SHALL have ports ic_rdata output LINE_W; ic_ready output 1 (I-cache transfer done).
REQ-006 SHALL have ports dc_read input 1; dc_write input 1; dc_addr input ADDR_W; dc_wdata input LINE_W; dc_rdata output LINE_W; dc_ready output 1 (D-cache side, same meanings).
REQ-007 SHALL have ports mem_read output 1; mem_write output 1; mem_addr output ADDR_W; mem_wdata output LINE_W; mem_rdata input LINE_W; mem_ready input 1 (single shared memory port).

Function
REQ-008 SHALL implement FSM states IDLE, GRANT_I, GRANT_D.
REQ-009 IDLE: a client requests when its read or write is high; if only one client requests, SHALL move to that client's GRANT state next cycle.
REQ-010 IDLE, both request: SHALL grant the client not granted last (round-robin via last_grant register).
REQ-011 On the IDLE->GRANT edge, SHALL latch the winner's address, wdata and op (write if write high, else read) into internal registers.
REQ-012 Client asserting read and write together: SHALL treat as write.
REQ-013 GRANT_x: mem_read/mem_write SHALL equal latched op AND NOT mem_ready; mem_addr/mem_wdata SHALL drive latched values.
REQ-014 GRANT_x with mem_ready high: x_ready SHALL be 1 in that same cycle, combinationally; x_rdata SHALL equal mem_rdata; FSM SHALL return to IDLE; last_grant SHALL become x.
REQ-015 x_ready SHALL be 0 for the non-granted client and in IDLE; mem_ready in IDLE SHALL be ignored.
REQ-016 x_rdata SHALL be a pass-through of mem_rdata for the granted client, 0 otherwise.
REQ-017 Arbitration latency: exactly one cycle from first request (IDLE) to mem_read/mem_write assertion.
REQ-018 A request arriving in the cycle its own ready is delivered SHALL NOT be served until the next IDLE cycle (back-to-back read-then-writeback from one cache costs one IDLE cycle).
REQ-019 A client SHALL be granted within one other transfer after requesting (no starvation).

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, last_grant=D, latched addr/wdata/op=0.
REQ-021 While in reset or IDLE, all mem_* and x_ready/x_rdata outputs SHALL be 0.
REQ-022 Reset mid-transfer SHALL abort immediately with no ready issued; memory is assumed reset with the arbiter.

Configuration
REQ-023 Macro MEM_ARB_DCACHE_PRIORITY_EN defined: on a tie in IDLE, D-cache SHALL always win; last_grant still updates but is unused.
REQ-024 Macro undefined: round-robin per REQ-010.

Structure
REQ-025 Package mem_arb_pkg SHALL hold the state enum, grant encoding (GNT_I=0, GNT_D=1) and default ADDR_W/LINE_W constants.
REQ-026 Sub-module mem_arb_pick SHALL contain the tie-break/winner selection (inputs: requests, last_grant; output: winner), including the macro switch.

Verification
REQ-027 Reset, then ic_read=1 ic_addr=0x0000010 -> cycle+1 mem_read=1 mem_addr=0x0000010; mem_ready=1 with mem_rdata=0xA5..A5 -> ic_ready=1, ic_rdata=0xA5..A5 same cycle, dc_ready=0.
REQ-028 ic_read and dc_read high same cycle after reset -> I granted first (last_grant=D); after its ready, D granted after one IDLE cycle; next tie -> I again.
REQ-029 dc_write=1 dc_addr=0x0ABCDEF dc_wdata=0x1234 -> mem_write=1, mem_addr=0x0ABCDEF, mem_wdata=0x1234, held 5 cycles until mem_ready, then dc_ready=1 and mem_write drops in that cycle.
REQ-030 With MEM_ARB_DCACHE_PRIORITY_EN defined, three consecutive ties -> D granted all three times.
REQ-031 rst_n pulsed low 3 cycles into a GRANT_D read -> mem_read=0 immediately, no dc_ready, FSM IDLE; mem_ready pulse while IDLE -> no x_ready.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-client memory arbiter.
// Holds the FSM state encoding, the grant encoding and default widths.
package mem_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  // Grant encoding: which client owns (or last owned) the memory port.
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Default line address width (tag + set index) and cache line width.
  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LINE_W = 128;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_pick.sv
// Winner selection for the memory arbiter.
// A lone requester always wins. On a tie the client not granted last wins,
// unless MEM_ARB_DCACHE_PRIORITY_EN is defined, in which case the D-cache
// always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic ic_req,
  input  logic dc_req,
  input  logic last_grant,
  output logic winner
);

  logic winner_s;

  // Tie-break: fixed D priority or round-robin against last_grant.
  always_comb begin
    winner_s = GNT_I;
    if (ic_req && dc_req) begin
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
      winner_s = GNT_D;
`else
      if (last_grant == GNT_I) begin
        winner_s = GNT_D;
      end else begin
        winner_s = GNT_I;
      end
`endif
    end else if (dc_req) begin
      winner_s = GNT_D;
    end else begin
      winner_s = GNT_I;
    end
  end

  assign winner = winner_s;

endmodule : mem_arb_pick

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of a single memory port.
// Requests are sampled in IDLE; the winner's op/address/data are latched on
// the IDLE->GRANT edge and replayed to memory until mem_ready. Ready and read
// data are returned combinationally in the mem_ready cycle.
// Optional feature macro: MEM_ARB_DCACHE_PRIORITY_EN (D-cache wins ties).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_read,
  input  logic              ic_write,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic [LINE_W-1:0] ic_wdata,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t              state_r;
  state_t              state_nxt_s;
  logic                last_grant_r;
  logic                last_grant_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   addr_nxt_s;
  logic [LINE_W-1:0]   wdata_r;
  logic [LINE_W-1:0]   wdata_nxt_s;
  logic                op_write_r;
  logic                op_write_nxt_s;
  logic                ic_req_s;
  logic                dc_req_s;
  logic                winner_s;

  // Read+write together counts as a request (and is served as a write).
  assign ic_req_s = ic_read | ic_write;
  assign dc_req_s = dc_read | dc_write;

  mem_arb_pick u_pick (
    .ic_req     (ic_req_s),
    .dc_req     (dc_req_s),
    .last_grant (last_grant_r),
    .winner     (winner_s)
  );

  // State, round-robin history and latched transfer; reset aborts any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= GNT_D;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {LINE_W{1'b0}};
      op_write_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      addr_r       <= addr_nxt_s;
      wdata_r      <= wdata_nxt_s;
      op_write_r   <= op_write_nxt_s;
    end
  end

  // Next-state logic: arbitrate and latch in IDLE, release on mem_ready.
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    addr_nxt_s       = addr_r;
    wdata_nxt_s      = wdata_r;
    op_write_nxt_s   = op_write_r;
    case (state_r)
      IDLE: begin
        if (ic_req_s || dc_req_s) begin
          if (winner_s == GNT_D) begin
            state_nxt_s    = GRANT_D;
            addr_nxt_s     = dc_addr;
            wdata_nxt_s    = dc_wdata;
            op_write_nxt_s = dc_write;
          end else begin
            state_nxt_s    = GRANT_I;
            addr_nxt_s     = ic_addr;
            wdata_nxt_s    = ic_wdata;
            op_write_nxt_s = ic_write;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT_I: begin
        if (mem_ready) begin
          state_nxt_s      = IDLE;
          last_grant_nxt_s = GNT_I;
        end else begin
          state_nxt_s = GRANT_I;
        end
      end
      GRANT_D: begin
        if (mem_ready) begin
          state_nxt_s      = IDLE;
          last_grant_nxt_s = GNT_D;
        end else begin
          state_nxt_s = GRANT_D;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode: memory strobes drop in the ready cycle; IDLE drives all zero.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {LINE_W{1'b0}};
    ic_ready  = 1'b0;
    ic_rdata  = {LINE_W{1'b0}};
    dc_ready  = 1'b0;
    dc_rdata  = {LINE_W{1'b0}};
    case (state_r)
      GRANT_I: begin
        mem_read  = ~op_write_r & ~mem_ready;
        mem_write = op_write_r & ~mem_ready;
        mem_addr  = addr_r;
        mem_wdata = wdata_r;
        ic_ready  = mem_ready;
        ic_rdata  = mem_rdata;
      end
      GRANT_D: begin
        mem_read  = ~op_write_r & ~mem_ready;
        mem_write = op_write_r & ~mem_ready;
        mem_addr  = addr_r;
        mem_wdata = wdata_r;
        dc_ready  = mem_ready;
        dc_rdata  = mem_rdata;
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

endmodule : mem_arbiter
